// File: rtl/wb_defs.sv
// Shared writeback definitions: datapath widths and load funct3 encodings used by
// the register file, decoder and writeback stage.
package wb_defs;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/load_extend.sv
// Load result extension: turns the raw loaded word into an XLEN value according to
// funct3. Unknown encodings pass the word through unchanged and raise err.
module load_extend
  import wb_defs::*;
#(
  parameter int XLEN = wb_defs::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] value,
  output logic            err
);

  always_comb begin
    value = data;
    err   = 1'b0;
    case (funct3)
      FUNCT3_LB:  value = {{(XLEN-8){data[7]}}, data[7:0]};
      FUNCT3_LH:  value = {{(XLEN-16){data[15]}}, data[15:0]};
      FUNCT3_LW:  value = data;
      FUNCT3_LBU: value = {{(XLEN-8){1'b0}}, data[7:0]};
      FUNCT3_LHU: value = {{(XLEN-16){1'b0}}, data[15:0]};
      default:    err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Register file write port arbiter: merges ALU and load results into one registered
// write, holding at most one load that lost the port to the ALU.
module reg_writeback
  import wb_defs::*;
#(
  parameter int XLEN       = wb_defs::XLEN,
  parameter int REG_ADDR_W = wb_defs::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [2:0]            ld_funct3,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_value,
  output logic                  ld_err,
  output logic [CNT_W-1:0]      wb_count
);

  buf_state_e            state;
  logic [REG_ADDR_W-1:0] buf_rd;
  logic [XLEN-1:0]       buf_value;

  logic [XLEN-1:0]       ext_value;
  logic                  ext_err;
  logic                  ld_acc;

  logic                  sel_vld_p0;
  logic [REG_ADDR_W-1:0] sel_rd_p0;
  logic [XLEN-1:0]       sel_value_p0;
  logic                  commit_p0;
  logic                  buf_load_p0;
  buf_state_e            state_nxt;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (ld_funct3),
    .data   (ld_data),
    .value  (ext_value),
    .err    (ext_err)
  );

  assign ld_ready = (state == BUF_EMPTY);
  assign ld_acc   = ld_valid && ld_ready;

  // Stage p0: source selection, ALU first, then the buffered load, then a fresh load.
  always_comb begin
    sel_vld_p0   = 1'b0;
    sel_rd_p0    = alu_rd;
    sel_value_p0 = alu_result;
    buf_load_p0  = 1'b0;
    state_nxt    = state;
    if (alu_valid) begin
      sel_vld_p0 = 1'b1;
      if (ld_acc) begin
        buf_load_p0 = 1'b1;
        state_nxt   = BUF_FULL;
      end else if (state == BUF_FULL && buf_rd == alu_rd) begin
        // The ALU result is younger, so the stale load must never reach the regfile.
        state_nxt = BUF_EMPTY;
      end
    end else if (state == BUF_FULL) begin
      sel_vld_p0   = 1'b1;
      sel_rd_p0    = buf_rd;
      sel_value_p0 = buf_value;
      state_nxt    = BUF_EMPTY;
    end else if (ld_acc) begin
      sel_vld_p0   = 1'b1;
      sel_rd_p0    = ld_rd;
      sel_value_p0 = ext_value;
    end
    commit_p0 = sel_vld_p0 && (sel_rd_p0 != '0);
  end

  // Stage p1: registered write port, buffer state and retired-write counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BUF_EMPTY;
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_value <= '0;
      ld_err   <= 1'b0;
      wb_count <= '0;
    end else begin
      state  <= state_nxt;
      wb_en  <= commit_p0;
      ld_err <= ld_acc && ext_err;
      if (sel_vld_p0) begin
        wb_rd    <= sel_rd_p0;
        wb_value <= sel_value_p0;
      end
      if (commit_p0) begin
        wb_count <= wb_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_load_p0) begin
      buf_rd    <= ld_rd;
      buf_value <= ext_value;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback against a transaction-level model
// of the write port, the one-entry load buffer and a shadow register file.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic        ld_err;
  logic [15:0] wb_count;

  int checks = 0;
  int errors = 0;

  // register file fed by the DUT, and the model's expected register file
  logic [31:0] rf  [32];
  logic [31:0] mrf [32];

  // model state
  bit          m_full;
  logic [4:0]  m_brd;
  logic [31:0] m_bval;
  logic        m_en;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_val;
  logic        m_err;
  logic [15:0] m_cnt;

  reg_writeback dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_data    (ld_data),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_value   (wb_value),
    .ld_err     (ld_err),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_en && wb_rd != 5'd0) rf[wb_rd] <= wb_value;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] d);
    int v;
    case (f3)
      3'd0: begin v = int'(d & 32'hFF);   if (v > 127)   v = v - 256;   end
      3'd1: begin v = int'(d & 32'hFFFF); if (v > 32767) v = v - 65536; end
      3'd4: v = int'(d & 32'hFF);
      3'd5: v = int'(d & 32'hFFFF);
      default: v = int'(d);
    endcase
    return 32'(v);
  endfunction

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] lf3,
                        input logic [31:0] ldat);
    alu_valid = av; alu_rd = ard; alu_result = ares;
    ld_valid = lv; ld_rd = lrd; ld_funct3 = lf3; ld_data = ldat;
  endtask

  task automatic model_reset();
    m_full = 0; m_en = 0; m_wb_rd = '0; m_wb_val = '0; m_err = 0; m_cnt = '0;
  endtask

  // one clock: predict from the inputs in force, advance, then compare all outputs
  task automatic cycle();
    bit          acc, bad, sv;
    logic [4:0]  srd;
    logic [31:0] sval, ext;
    acc  = ld_valid && !m_full;
    ext  = m_ext(ld_funct3, ld_data);
    bad  = !(ld_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sv   = 0; srd = '0; sval = '0;
    if (alu_valid) begin
      sv = 1; srd = alu_rd; sval = alu_result;
      if (acc) begin
        m_full = 1; m_brd = ld_rd; m_bval = ext;
      end else if (m_full && m_brd == alu_rd) begin
        m_full = 0;
      end
    end else if (m_full) begin
      sv = 1; srd = m_brd; sval = m_bval; m_full = 0;
    end else if (acc) begin
      sv = 1; srd = ld_rd; sval = ext;
    end
    m_en = sv && (srd != 5'd0);
    if (sv) begin m_wb_rd = srd; m_wb_val = sval; end
    if (m_en) begin m_cnt = m_cnt + 16'd1; mrf[srd] = sval; end
    m_err = acc && bad;
    @(posedge clk); #1;
    chk("wb_en",    32'(wb_en),    32'(m_en));
    chk("wb_rd",    32'(wb_rd),    32'(m_wb_rd));
    chk("wb_value", wb_value,      m_wb_val);
    chk("ld_err",   32'(ld_err),   32'(m_err));
    chk("wb_count", 32'(wb_count), 32'(m_cnt));
    chk("ld_ready", 32'(ld_ready), 32'(!m_full));
  endtask

  initial begin
    logic [15:0] c0;
    logic [31:0] prev;
    for (int i = 0; i < 32; i++) begin rf[i] = '0; mrf[i] = '0; end
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    reset = 1'b0;
    #12;
    chk("rst_wb_en",    32'(wb_en),    32'd0);
    chk("rst_wb_rd",    32'(wb_rd),    32'd0);
    chk("rst_wb_value", wb_value,      32'd0);
    chk("rst_ld_err",   32'(ld_err),   32'd0);
    chk("rst_wb_count", 32'(wb_count), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // ALU write lands in x5
    set_in(1, 5, 32'h1234, 0, 0, 0, 0);
    cycle();
    chk("t1_value", wb_value, 32'h1234);
    chk("t1_count", 32'(wb_count), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("t1_rf_x5", rf[5], 32'h1234);

    // load extension
    set_in(0, 0, 0, 1, 6, 3'b000, 32'h80);
    cycle();
    chk("t2_lb", wb_value, 32'hFFFFFF80);
    set_in(0, 0, 0, 1, 6, 3'b100, 32'h80);
    cycle();
    chk("t2_lbu", wb_value, 32'h00000080);
    set_in(0, 0, 0, 1, 6, 3'b001, 32'h8001);
    cycle();
    chk("t2_lh", wb_value, 32'hFFFF8001);

    // collision: ALU wins, load follows a cycle later
    c0 = wb_count;
    set_in(1, 3, 32'hA, 1, 4, 3'b010, 32'hB);
    cycle();
    chk("t3_c1_rd", 32'(wb_rd), 32'd3);
    chk("t3_c1_ready", 32'(ld_ready), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t3_c2_rd", 32'(wb_rd), 32'd4);
    chk("t3_c2_value", wb_value, 32'hB);
    chk("t3_c2_ready", 32'(ld_ready), 32'd1);
    chk("t3_count", 32'(wb_count - c0), 32'd2);

    // buffered load to x7 superseded by a younger ALU write to x7
    set_in(1, 1, 32'h11, 1, 7, 3'b010, 32'h77);
    cycle();
    set_in(1, 7, 32'h55, 0, 0, 0, 0);
    cycle();
    chk("t4_value", wb_value, 32'h55);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t4_idle_en", 32'(wb_en), 32'd0);
    @(negedge clk); #1;
    chk("t4_rf_x7", rf[7], 32'h55);

    // x0 suppression and illegal funct3
    c0 = wb_count;
    set_in(1, 0, 32'hFF, 0, 0, 0, 0);
    cycle();
    chk("t5_x0_en", 32'(wb_en), 32'd0);
    chk("t5_x0_count", 32'(wb_count), 32'(c0));
    set_in(0, 0, 0, 1, 8, 3'b011, 32'h12345678);
    cycle();
    chk("t5_err", 32'(ld_err), 32'd1);
    chk("t5_lw", wb_value, 32'h12345678);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t5_err_clr", 32'(ld_err), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), $urandom);
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    @(negedge clk); #1;
    for (int r = 1; r < 32; r++) chk($sformatf("rf_x%0d", r), rf[r], mrf[r]);

    // reset while a write is in flight and the buffer is full
    prev = rf[1];
    set_in(1, 1, 32'hDEAD0001, 1, 9, 3'b010, 32'h99);
    cycle();
    #2 reset = 1'b0;
    #1;
    chk("t6_wb_en", 32'(wb_en), 32'd0);
    chk("t6_ready", 32'(ld_ready), 32'd1);
    chk("t6_count", 32'(wb_count), 32'd0);
    @(negedge clk); #1;
    chk("t6_rf_x1", rf[1], prev);
    mrf[1] = prev;
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_ready_rel", 32'(ld_ready), 32'd1);

    // counter wrap
    set_in(1, 2, 32'h2, 0, 0, 0, 0);
    for (int n = 0; n < 65535; n++) cycle();
    chk("wrap_max", 32'(wb_count), 32'h0000FFFF);
    cycle();
    chk("wrap_zero", 32'(wb_count), 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
